// File: rtl/div_root_pkg.sv
// div_root_pkg: shared state encoding, mode constants and width helpers for the divide/root engine
package div_root_pkg;
  typedef enum logic [2:0] {IDLE, DIV, R_LOAD, R_MUL, R_CMP, RND, ERR, DONE} state_t;
  localparam logic MODE_DIV  = 1'b0;
  localparam logic MODE_ROOT = 1'b1;
  function automatic int calc_res_w(input int int_w, input int frac_w);
    return int_w + frac_w;
  endfunction
  function automatic int calc_p_w(input int int_w, input int frac_w, input int deg_w);
    return int_w + frac_w * ((1 << deg_w) - 1);
  endfunction
endpackage

// File: rtl/div_root_sat_mul.sv
// div_root_sat_mul: combinational power x trial multiply, clamped to all-ones when the product overflows
module div_root_sat_mul #(
  parameter int PW = 80,
  parameter int RW = 20
) (
  input  logic [PW-1:0] i_a,
  input  logic [RW-1:0] i_b,
  output logic [PW-1:0] o_p
);
  logic [PW+RW-1:0] w_full;
  assign w_full = i_a * i_b;
  assign o_p    = |w_full[PW+RW-1:PW] ? '1 : w_full[PW-1:0];
endmodule

// File: rtl/div_root_engine.sv
// div_root_engine: iterative divide / n-th root, one result bit per step; DIVROOT_ROUND_EN adds a guard bit and round-half-up
module div_root_engine import div_root_pkg::*; #(
  parameter int INT_W = 10,
  parameter int FRAC_W = 10,
  parameter int DEG_W = 3,
  localparam int RES_W = calc_res_w(INT_W, FRAC_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [INT_W-1:0] in_data_1,
  input  logic [DEG_W-1:0] in_data_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_data,
  output logic             out_err
);
`ifdef DIVROOT_ROUND_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif
  localparam int FW = FRAC_W + G;
  localparam int CW = RES_W + G;
  localparam int PW = calc_p_w(INT_W, FW, DEG_W);
  localparam int IW = $clog2(CW);
  state_t           r_state, w_next;
  logic             r_boot, r_err;
  logic [INT_W-1:0] r_d1;
  logic [DEG_W-1:0] r_n, r_cnt, r_rem;
  logic [CW-1:0]    r_q, r_y, w_bit, w_qn, w_half;
  logic [PW-1:0]    r_p, w_prod, w_tgt;
  logic [IW-1:0]    r_idx;
  logic [RES_W-1:0] r_out, w_rnd;
  logic [DEG_W:0]   w_trial, w_sub;
  logic             w_acc, w_ge, w_fit;
  assign w_acc   = in_valid & in_ready;
  assign w_bit   = CW'(1) << r_idx;
  assign w_trial = {r_rem, r_q[CW-1]};
  assign w_ge    = w_trial >= {1'b0, r_n};
  assign w_sub   = w_trial - {1'b0, r_n};
  assign w_tgt   = PW'(r_d1) << (FW * r_n);
  assign w_fit   = r_p <= w_tgt;
  assign w_qn    = r_state == DIV ? {r_q[CW-2:0], w_ge} : w_fit ? r_y : r_q;
  assign w_half  = {1'b0, r_q[CW-1:1]} + CW'(r_q[0]);
  assign w_rnd   = (G != 0) && w_half[CW-1] ? '1 : w_half[RES_W-1:0];
  assign in_ready  = r_boot & (r_state == IDLE);
  assign out_valid = r_state == DONE;
  assign out_data  = r_out;
  assign out_err   = r_err;
  div_root_sat_mul #(.PW(PW), .RW(CW)) u_mul (.i_a(r_p), .i_b(r_y), .o_p(w_prod));
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next-state: divide runs one bit per cycle, root spends n+1 cycles per bit
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_next = in_data_2 == '0 ? ERR : in_mode == MODE_ROOT ? R_LOAD : DIV;
      DIV:     if (r_idx == '0) w_next = G != 0 ? RND : DONE;
      R_LOAD:  w_next = r_n == DEG_W'(1) ? R_CMP : R_MUL;
      R_MUL:   if (r_cnt == DEG_W'(1)) w_next = R_CMP;
      R_CMP:   w_next = r_idx != '0 ? R_LOAD : G != 0 ? RND : DONE;
      RND:     w_next = DONE;
      ERR:     w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // datapath: capture, restoring division, trial-power search, rounding and output hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_boot <= 1'b0;
      r_out  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_boot <= 1'b1;
      case (r_state)
        IDLE: if (w_acc) begin
          r_d1  <= in_data_1;
          r_n   <= in_data_2;
          r_rem <= '0;
          r_err <= in_data_2 == '0;
          r_q   <= in_mode == MODE_DIV ? CW'(in_data_1) << FW : '0;
          r_idx <= IW'(CW - 1);
        end
        DIV: begin
          r_rem <= w_ge ? w_sub[DEG_W-1:0] : w_trial[DEG_W-1:0];
          r_q   <= w_qn;
          r_idx <= r_idx - 1'b1;
          if (w_next == DONE) r_out <= w_qn[RES_W-1:0];
        end
        R_LOAD: begin
          r_y   <= r_q | w_bit;
          r_p   <= PW'(r_q | w_bit);
          r_cnt <= r_n - 1'b1;
        end
        R_MUL: begin
          r_p   <= w_prod;
          r_cnt <= r_cnt - 1'b1;
        end
        R_CMP: begin
          r_q   <= w_qn;
          r_idx <= r_idx - 1'b1;
          if (w_next == DONE) r_out <= w_qn[RES_W-1:0];
        end
        RND: r_out <= w_rnd;
        ERR: r_out <= '1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_root_engine.sv
// tb_div_root_engine: randomized and directed checks of div_root_engine against an arithmetic reference model
module tb_div_root_engine;
  localparam int INT_W = 10;
  localparam int FRAC_W = 10;
  localparam int DEG_W = 3;
  localparam int RES_W = INT_W + FRAC_W;
`ifdef DIVROOT_ROUND_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif
  localparam int FW = FRAC_W + G;
  localparam int CW = RES_W + G;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b0;
  logic [INT_W-1:0] in_data_1 = '0;
  logic [DEG_W-1:0] in_data_2 = '0;
  logic in_ready, out_valid, out_err;
  logic [RES_W-1:0] out_data;
  int n_tests = 0, n_fail = 0;

  div_root_engine #(.INT_W(INT_W), .FRAC_W(FRAC_W), .DEG_W(DEG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data_1(in_data_1), .in_data_2(in_data_2), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // floor(a*2^FW/b) or the largest y with y^b <= a*2^(FW*b), then optional round-half-up
  function automatic logic [RES_W-1:0] model(input logic m, input int a, input int b);
    logic [255:0] r, tgt, lo, hi, mid, p, maxr;
    maxr = (256'(1) << RES_W) - 1;
    if (b == 0) return '1;
    if (m == 1'b0) r = (256'(a) << FW) / 256'(b);
    else begin
      tgt = 256'(a) << (FW * b);
      lo = '0;
      hi = (256'(1) << CW) - 1;
      while (lo < hi) begin
        mid = (lo + hi + 1) >> 1;
        p = 256'(1);
        for (int i = 0; i < b; i++) p = p * mid;
        if (p <= tgt) lo = mid; else hi = mid - 1;
      end
      r = lo;
    end
`ifdef DIVROOT_ROUND_EN
    r = (r + 1) >> 1;
    if (r > maxr) r = maxr;
`endif
    return RES_W'(r);
  endfunction

  function automatic int exp_lat(input logic m, input int b);
    if (b == 0) return 2;
    return m ? CW * (b + 1) + 1 + G : CW + 1 + G;
  endfunction

  task automatic send(input logic m, input logic [INT_W-1:0] a, input logic [DEG_W-1:0] b, output bit to);
    int k = 0;
    while (!in_ready && k < 400) begin @(posedge clk); #1; k++; end
    to = !in_ready;
    in_valid = 1'b1; in_mode = m; in_data_1 = a; in_data_2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_mode = 1'($urandom); in_data_1 = INT_W'($urandom); in_data_2 = DEG_W'($urandom);
  endtask

  task automatic do_op(input logic m, input logic [INT_W-1:0] a, input logic [DEG_W-1:0] b,
                       output logic [RES_W-1:0] d, output logic e, output int lat, output bit to);
    send(m, a, b, to);
    lat = 1;
    while (!out_valid && lat < 400) begin @(posedge clk); #1; lat++; end
    to = to | !out_valid;
    d = out_data; e = out_err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_err !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b data=%h err=%b ready=%b, required 0 0 0 0", out_valid, out_data, out_err, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic dm [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int da [10] = '{10, 27, 2, 1023, 2, 1, 5, 9, 0, 1023};
    int db [10] = '{4, 3, 2, 1, 3, 3, 0, 0, 5, 1};
    logic [RES_W-1:0] d, x; logic e; int lat; bit to;
    for (int i = 0; i < 10; i++) begin
      do_op(dm[i], INT_W'(da[i]), DEG_W'(db[i]), d, e, lat, to);
      x = model(dm[i], da[i], db[i]);
      n_tests++;
      if (to || d !== x || e !== (db[i] == 0)) begin
        n_fail++;
        $display("FAIL directed[%0d] m=%0d a=%0d b=%0d: data=%h err=%b timeout=%0d, required data=%h err=%b", i, dm[i], da[i], db[i], d, e, to, x, db[i] == 0);
      end
      n_tests++;
      if (lat !== exp_lat(dm[i], db[i])) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: %0d cycles, required %0d", i, lat, exp_lat(dm[i], db[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [RES_W-1:0] d, x; logic e; int lat; bit to; logic m; int a, b;
    for (int i = 0; i < 30; i++) begin
      m = 1'($urandom); a = int'($urandom_range(0, 1023)); b = int'($urandom_range(0, 7));
      do_op(m, INT_W'(a), DEG_W'(b), d, e, lat, to);
      x = model(m, a, b);
      n_tests++;
      if (to || d !== x || e !== (b == 0) || lat !== exp_lat(m, b)) begin
        n_fail++;
        $display("FAIL random[%0d] m=%0d a=%0d b=%0d: data=%h err=%b lat=%0d, required data=%h err=%b lat=%0d", i, m, a, b, d, e, lat, x, b == 0, exp_lat(m, b));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [RES_W-1:0] x; bit to; int k = 0; int a, b;
    a = int'($urandom_range(1, 1023)); b = int'($urandom_range(1, 7));
    x = model(1'b0, a, b);
    send(1'b0, INT_W'(a), DEG_W'(b), to);
    while (!out_valid && k < 400) begin @(posedge clk); #1; k++; end
    n_tests++;
    if (to || !out_valid) begin
      n_fail++;
      $display("FAIL bp_start: out_valid=%b, required 1", out_valid);
    end
    for (int c = 0; c < 10; c++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== x || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h ready=%b, required 1 %h 0", c, out_valid, out_data, in_ready, x);
      end
      in_valid = 1'b1; in_mode = 1'($urandom); in_data_1 = INT_W'($urandom); in_data_2 = DEG_W'($urandom);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== x) begin
      n_fail++;
      $display("FAIL bp_after_pulses: valid=%b data=%h, required 1 %h", out_valid, out_data, x);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midroot();
    logic [RES_W-1:0] d, x; logic e; int lat; bit to;
    send(1'b1, INT_W'(1000), DEG_W'(7), to);
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midroot_reset: valid=%b data=%h err=%b, required 0 0 0", out_valid, out_data, out_err);
    end
    do_op(1'b1, INT_W'(27), DEG_W'(3), d, e, lat, to);
    x = model(1'b1, 27, 3);
    n_tests++;
    if (to || d !== x || e !== 1'b0 || lat !== exp_lat(1'b1, 3)) begin
      n_fail++;
      $display("FAIL midroot_recover: data=%h err=%b lat=%0d, required data=%h err=0 lat=%0d", d, e, lat, x, exp_lat(1'b1, 3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midroot();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
